truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequencer that drives a 4-input combinational function block (a, b, c, d -> f) through all 16 input combinations in ascending order. Each combination is held for a programmable number of cycles. On the last hold cycle of each combination, f is sampled into a 16-bit truth-table register. Used as a synthesizable on-chip replacement for exhaustive bench sweeps; a start/busy/done handshake connects it to a host or top-level controller.

Parameters:
HOLD_CYCLES, 20, cycles each input combination is driven before f is sampled; legal range 1..255.

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-high; clears all state
start  in  1  single-cycle request to begin a sweep; honoured only in IDLE
f_in  in  1  output of the function block under control
a  out  1  function input, MSB (vec[3])
b  out  1  function input (vec[2])
c  out  1  function input (vec[1])
d  out  1  function input, LSB (vec[0])
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the sweep completes
table_out  out  16  bit i = sampled f for vec == i
table_valid  out  1  table_out holds a complete sweep

Behaviour:
- Reset values (async, immediate): state=IDLE, vec=0 (a=b=c=d=0), hold_cnt=0, busy=0, done=0, table_out=16'h0000, table_valid=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - vec=0.
  - If start=1: next state RUN, table_out cleared, table_valid cleared, hold_cnt=0.
- RUN:
  - busy=1 and vec is driven on a..d.
  - hold_cnt increments each cycle.
  - When hold_cnt == HOLD_CYCLES-1: table_out[vec] <= f_in, hold_cnt <= 0.
  - At that same point, if vec==15: vec <= 0 and next state DONE; otherwise vec <= vec+1.
- DONE: lasts exactly one cycle with done=1, busy=0, table_valid <= 1, then IDLE.
- Latency: with start sampled high at edge E0, done is high in the cycle following edge E0 + 16*HOLD_CYCLES + 1.
- start while in RUN or DONE is ignored; there is no queuing.
- table_out and table_valid hold after DONE until the next accepted start or reset.
- vec is 4 bits with no wrap-around beyond 15; the transition 15 -> 0 occurs only on exit to DONE.
- hold_cnt width is $clog2(HOLD_CYCLES+1), minimum 1 bit.
- Reset asserted mid-sweep aborts immediately to reset values; the partial table is discarded.
- All outputs are registered; there are no combinational paths from f_in or start to any output.

Optional Feature:
Macro SWEEP_COMPARE_EN.
- Defined:
  - Adds port expected_in (in, 16).
  - Adds port mismatch (out, 1), set in DONE to (table_out != expected_in).
  - Adds port mismatch_cnt (out, 5), set in DONE to popcount(table_out ^ expected_in).
  - Both new outputs reset to 0 and are cleared on an accepted start.
  - expected_in is sampled only in DONE.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package sweeper_pkg: state enum {IDLE, RUN, DONE}; VEC_W=4; NUM_VEC=16; TABLE_W=16.
- Sub-module hold_timer:
  - Parameterized by HOLD_CYCLES.
  - Inputs: clear, enable.
  - Output: last (hold_cnt == HOLD_CYCLES-1).
  - The FSM, vec counter and table register live in the top.

Test Plan:
1. Reset asserted for 3 cycles, then released, no start -> a..d=0, busy=0, done=0, table_out=0, table_valid=0; async clear observed mid-cycle.
2. HOLD_CYCLES=2, f=a^b^c^d, start pulse at E0 -> busy high 32 cycles, done pulse after E0+33, table_out=16'h6996, table_valid=1.
3. HOLD_CYCLES=2, second start pulse 10 cycles into sweep -> ignored; single done pulse at the same cycle as test 2; table_out=16'h6996.
4. Reset pulse 15 cycles into sweep -> immediate return to reset values; fresh start yields full sweep, table_out=16'h6996.
5. HOLD_CYCLES=1, f=d -> done after E0+17, table_out=16'hAAAA; vec sequence 0..15 observed one per cycle.
6. SWEEP_COMPARE_EN, f=a&b&c&d, expected_in=16'h6996 -> table_out=16'h8000, mismatch=1, mismatch_cnt=9; rerun with expected_in=16'h8000 -> mismatch=0, mismatch_cnt=0.

Source files
------------

// File: rtl/sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package sweeper_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;
    localparam int TABLE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of set bits in a 16-bit word; 5 bits covers the all-ones case.
    function automatic logic [4:0] popcount16(input logic [TABLE_W-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < TABLE_W; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// Hold timer: counts cycles while enabled and flags the last hold cycle of
// each input combination. Wraps to zero on its own after the last cycle.
module hold_timer #(
    parameter int HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CNT_W = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;

    assign last = (hold_cnt_q == LAST_VAL);

    // Next count: clear wins, otherwise advance and wrap on the last cycle.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (clear) begin
            hold_cnt_d = '0;
        end else if (enable) begin
            if (last) begin
                hold_cnt_d = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives a..d through 0..15, holds each combination for
// HOLD_CYCLES cycles and samples f_in on the last hold cycle into table_out.
// Optional golden-table compare is enabled with the SWEEP_COMPARE_EN macro.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               f_in,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               busy,
    output logic               done,
    output logic [TABLE_W-1:0] table_out,
    output logic               table_valid
`ifdef SWEEP_COMPARE_EN
    ,
    input  logic [TABLE_W-1:0] expected_in,
    output logic               mismatch,
    output logic [4:0]         mismatch_cnt
`endif
);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TABLE_W-1:0] table_q, table_d;
    logic               valid_q, valid_d;
    logic               timer_clear;
    logic               timer_en;
    logic               hold_last;
`ifdef SWEEP_COMPARE_EN
    logic               mismatch_q, mismatch_d;
    logic [4:0]         mcnt_q, mcnt_d;
`endif

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .enable(timer_en),
        .last  (hold_last)
    );

    assign a           = vec_q[3];
    assign b           = vec_q[2];
    assign c           = vec_q[1];
    assign d           = vec_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign table_out   = table_q;
    assign table_valid = valid_q;
`ifdef SWEEP_COMPARE_EN
    assign mismatch     = mismatch_q;
    assign mismatch_cnt = mcnt_q;
`endif

    // Sequencer next-state and registered-output logic. busy/done are computed
    // one cycle ahead so the outputs come straight from flops.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        table_d     = table_q;
        valid_d     = valid_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
`ifdef SWEEP_COMPARE_EN
        mismatch_d  = mismatch_q;
        mcnt_d      = mcnt_q;
`endif
        case (state_q)
            IDLE: begin
                vec_d       = '0;
                timer_clear = 1'b1;
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    table_d = '0;
                    valid_d = 1'b0;
`ifdef SWEEP_COMPARE_EN
                    mismatch_d = 1'b0;
                    mcnt_d     = '0;
`endif
                end
            end
            RUN: begin
                timer_en = 1'b1;
                busy_d   = 1'b1;
                if (hold_last) begin
                    table_d[vec_q] = f_in;
                    if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                        vec_d   = '0;
                        state_d = DONE;
                        busy_d  = 1'b0;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            DONE: begin
                timer_clear = 1'b1;
                done_d      = 1'b1;
                valid_d     = 1'b1;
                state_d     = IDLE;
`ifdef SWEEP_COMPARE_EN
                mismatch_d  = (table_q != expected_in);
                mcnt_d      = popcount16(table_q ^ expected_in);
`endif
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= '0;
            valid_q    <= 1'b0;
`ifdef SWEEP_COMPARE_EN
            mismatch_q <= 1'b0;
            mcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            table_q    <= table_d;
            valid_q    <= valid_d;
`ifdef SWEEP_COMPARE_EN
            mismatch_q <= mismatch_d;
            mcnt_q     <= mcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with HOLD_CYCLES=2, one with
// HOLD_CYCLES=1, a table of sweeps plus hand-written reset/compare sequences.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    logic f1, f2;
    logic a1, b1, c1, d1, busy1, done1, valid1;
    logic a2, b2, c2, d2, busy2, done2, valid2;
    logic [15:0] tbl1, tbl2;
    logic [15:0] exp_in = 16'h0000;
    int fmode = 0;
    int sel = 2;
    int n_cmp = 0;
    int n_fail = 0;
`ifdef SWEEP_COMPARE_EN
    logic mism1, mism2;
    logic [4:0] mcnt1, mcnt2;
`endif

    always #5 clk = ~clk;

    function automatic logic ffun(input int m, input logic [3:0] v);
        case (m)
            0: return ^v;
            1: return v[0];
            2: return &v;
            3: return v[3];
            4: return v[1];
            default: return 1'b0;
        endcase
    endfunction

    assign f1 = ffun(fmode, {a1, b1, c1, d1});
    assign f2 = ffun(fmode, {a2, b2, c2, d2});

    truth_table_sweeper #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .f_in(f1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .table_out(tbl1), .table_valid(valid1)
`ifdef SWEEP_COMPARE_EN
        , .expected_in(exp_in), .mismatch(mism1), .mismatch_cnt(mcnt1)
`endif
    );

    truth_table_sweeper #(.HOLD_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .f_in(f2),
        .a(a2), .b(b2), .c(c2), .d(d2),
        .busy(busy2), .done(done2), .table_out(tbl2), .table_valid(valid2)
`ifdef SWEEP_COMPARE_EN
        , .expected_in(exp_in), .mismatch(mism2), .mismatch_cnt(mcnt2)
`endif
    );

    wire [3:0]  vec_s   = (sel == 1) ? {a1, b1, c1, d1} : {a2, b2, c2, d2};
    wire        busy_s  = (sel == 1) ? busy1 : busy2;
    wire        done_s  = (sel == 1) ? done1 : done2;
    wire [15:0] tbl_s   = (sel == 1) ? tbl1 : tbl2;
    wire        valid_s = (sel == 1) ? valid1 : valid2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 1) start1 = v;
        else        start2 = v;
    endtask

    // One full sweep on instance s; extra >= 0 injects a second start pulse
    // k cycles into the sweep, which must be ignored.
    task automatic run_sweep(input int s, input int extra, input logic [15:0] exp_tbl);
        int h, busy_n, ndone, done_k;
        h = (s == 1) ? 1 : 2;
        sel = s;
        busy_n = 0;
        ndone = 0;
        done_k = -1;
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        for (int k = 0; k < 16 * h + 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                set_start(s, 1'b0);
                chk("valid_cleared_on_start", 32'(valid_s), 32'd0);
            end
            if (k == extra) set_start(s, 1'b1);
            if (extra >= 0 && k == extra + 1) set_start(s, 1'b0);
            if (busy_s) busy_n++;
            if (done_s) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (k < 16 * h) chk("vec_seq", 32'(vec_s), 32'(k / h));
            if (k == 16 * h + 2) chk("vec_idle", 32'(vec_s), 32'd0);
        end
        chk("busy_cycles", 32'(busy_n), 32'(16 * h));
        chk("done_pulses", 32'(ndone), 32'd1);
        chk("done_latency", 32'(done_k), 32'(16 * h + 1));
        chk("table_out", 32'(tbl_s), 32'(exp_tbl));
        chk("table_valid", 32'(valid_s), 32'd1);
    endtask

    typedef struct {
        int          s;
        int          fm;
        logic [15:0] exp_tbl;
        int          extra;
    } vec_t;

    vec_t tv[6];

    initial begin
        tv[0] = '{s: 2, fm: 0, exp_tbl: 16'h6996, extra: -1};
        tv[1] = '{s: 2, fm: 0, exp_tbl: 16'h6996, extra: 10};
        tv[2] = '{s: 1, fm: 1, exp_tbl: 16'hAAAA, extra: -1};
        tv[3] = '{s: 2, fm: 2, exp_tbl: 16'h8000, extra: -1};
        tv[4] = '{s: 1, fm: 3, exp_tbl: 16'hFF00, extra: -1};
        tv[5] = '{s: 2, fm: 4, exp_tbl: 16'hCCCC, extra: -1};

        // Reset held for three cycles, then released with no start.
        repeat (3) @(negedge clk);
        chk("rst_vec", 32'({a2, b2, c2, d2}), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_table", 32'(tbl2), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_vec", 32'({a2, b2, c2, d2, a1, b1, c1, d1}), 32'd0);
        chk("idle_busy_done", 32'({busy1, done1, busy2, done2}), 32'd0);
        chk("idle_table", 32'({tbl1, tbl2}), 32'd0);
        chk("idle_valid", 32'({valid1, valid2}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            fmode = tv[i].fm;
            run_sweep(tv[i].s, tv[i].extra, tv[i].exp_tbl);
        end

        // Reset 15 cycles into a sweep: asynchronous, observed mid-cycle.
        fmode = 0;
        sel = 2;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst_busy", 32'(busy2), 32'd1);
        chk("pre_rst_table", 32'(tbl2), 32'h0016);
        #1 reset = 1'b1;
        #1;
        chk("async_vec", 32'({a2, b2, c2, d2}), 32'd0);
        chk("async_busy", 32'(busy2), 32'd0);
        chk("async_table", 32'(tbl2), 32'd0);
        chk("async_valid", 32'(valid2), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_done", 32'(done2), 32'd0);
        run_sweep(2, -1, 16'h6996);

`ifdef SWEEP_COMPARE_EN
        fmode = 2;
        exp_in = 16'h6996;
        run_sweep(2, -1, 16'h8000);
        chk("mismatch_set", 32'(mism2), 32'd1);
        chk("mismatch_cnt9", 32'(mcnt2), 32'd9);
        exp_in = 16'h8000;
        run_sweep(2, -1, 16'h8000);
        chk("mismatch_clr", 32'(mism2), 32'd0);
        chk("mismatch_cnt0", 32'(mcnt2), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
